// File: rtl/xbus_scheduler.sv
// -----------------------------------------------------------------------------
// xbus_scheduler
//   Row-bus sequencer for one PE row. Per job it pulses a kernel/tag flush,
//   loads cfg_kernel_size filter words into every column, then streams
//   cfg_num_ifmap ifmap words into every column. Words arrive from the global
//   buffer on valid/ready streams and leave on the row bus, registered, tagged
//   with the target column (bus_x_id).
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   cfg_start              single-cycle job start (honoured only when idle)
//   cfg_kernel_size        filter words per column (K)
//   cfg_num_ifmap          ifmap words per column (N)
//   gb_fltr_*              filter stream from the global buffer
//   gb_ifmap_*             ifmap stream from the global buffer
//   pe_ready               per-column accept capability
//   bus_*                  registered row-bus outputs, latched K
//   flush_kernel/flush_tag one-cycle flush pulse at job start
//   busy, done             job in progress / one-cycle completion pulse
//
// Optional build macro XBUS_SCHED_STALL_CNT_EN adds a 32-bit saturating
// stall_cnt output: cycles in which the active stream is valid but the
// addressed column cannot accept.
// -----------------------------------------------------------------------------
module xbus_scheduler #(
    parameter  int DATA_WIDTH = 16,
    parameter  int NUM_COL    = 4,
    parameter  int CNT_W      = 16,
    localparam int ID_W       = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cfg_start,
    input  logic [7:0]            cfg_kernel_size,
    input  logic [CNT_W-1:0]      cfg_num_ifmap,
    input  logic                  gb_fltr_valid,
    input  logic [DATA_WIDTH-1:0] gb_fltr_data,
    output logic                  gb_fltr_ready,
    input  logic                  gb_ifmap_valid,
    input  logic [DATA_WIDTH-1:0] gb_ifmap_data,
    output logic                  gb_ifmap_ready,
    input  logic [NUM_COL-1:0]    pe_ready,
    output logic [ID_W-1:0]       bus_x_id,
    output logic [DATA_WIDTH-1:0] bus_fltr_data,
    output logic                  bus_fltr_en,
    output logic [DATA_WIDTH-1:0] bus_ifmap_data,
    output logic                  bus_ifmap_en,
    output logic [7:0]            bus_kernel_size,
    output logic                  flush_kernel,
    output logic                  flush_tag,
    output logic                  busy,
`ifdef XBUS_SCHED_STALL_CNT_EN
    output logic [31:0]           stall_cnt,
`endif
    output logic                  done
);

    typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_FLTR, S_IFMAP, S_DONE} state_e;

    localparam logic [ID_W-1:0] LAST_COL = ID_W'(NUM_COL - 1);

    state_e                 state_q, state_d;
    logic [7:0]             k_q, k_d;
    logic [CNT_W-1:0]       n_q, n_d;
    logic [ID_W-1:0]        col_q, col_d;
    logic [CNT_W-1:0]       wcnt_q, wcnt_d;
    logic [ID_W-1:0]        bus_x_id_q, bus_x_id_d;
    logic [DATA_WIDTH-1:0]  fltr_data_q, fltr_data_d;
    logic [DATA_WIDTH-1:0]  ifmap_data_q, ifmap_data_d;
    logic                   fltr_en_q, fltr_en_d;
    logic                   ifmap_en_q, ifmap_en_d;

    logic                   col_last;
    logic [ID_W-1:0]        col_next;
    logic [CNT_W-1:0]       k_last;
    logic [CNT_W-1:0]       n_last;
    logic                   pe_rdy_cur;

    // Explicit compare keeps the column walk correct for non-power-of-two rows.
    assign col_last   = (col_q == LAST_COL);
    assign col_next   = col_last ? '0 : col_q + ID_W'(1);
    assign k_last     = CNT_W'(k_q) - CNT_W'(1);
    assign n_last     = n_q - CNT_W'(1);
    assign pe_rdy_cur = pe_ready[col_q];

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        n_d            = n_q;
        col_d          = col_q;
        wcnt_d         = wcnt_q;
        bus_x_id_d     = bus_x_id_q;
        fltr_data_d    = fltr_data_q;
        ifmap_data_d   = ifmap_data_q;
        fltr_en_d      = 1'b0;
        ifmap_en_d     = 1'b0;
        gb_fltr_ready  = 1'b0;
        gb_ifmap_ready = 1'b0;
        flush_kernel   = 1'b0;
        flush_tag      = 1'b0;
        done           = 1'b0;
        busy           = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (cfg_start) begin
                    k_d     = cfg_kernel_size;
                    n_d     = cfg_num_ifmap;
                    col_d   = '0;
                    wcnt_d  = '0;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                flush_kernel = 1'b1;
                flush_tag    = 1'b1;
                if (k_q != 8'd0)      state_d = S_FLTR;
                else if (n_q != '0)   state_d = S_IFMAP;
                else                  state_d = S_DONE;
            end
            S_FLTR: begin
                gb_fltr_ready = pe_rdy_cur;
                if (gb_fltr_valid && pe_rdy_cur) begin
                    fltr_data_d = gb_fltr_data;
                    bus_x_id_d  = col_q;
                    fltr_en_d   = 1'b1;
                    if (wcnt_q == k_last) begin
                        wcnt_d = '0;
                        col_d  = col_next;
                        if (col_last) state_d = (n_q != '0) ? S_IFMAP : S_DONE;
                    end else begin
                        wcnt_d = wcnt_q + CNT_W'(1);
                    end
                end
            end
            S_IFMAP: begin
                gb_ifmap_ready = pe_rdy_cur;
                if (gb_ifmap_valid && pe_rdy_cur) begin
                    ifmap_data_d = gb_ifmap_data;
                    bus_x_id_d   = col_q;
                    ifmap_en_d   = 1'b1;
                    if (wcnt_q == n_last) begin
                        wcnt_d = '0;
                        col_d  = col_next;
                        if (col_last) state_d = S_DONE;
                    end else begin
                        wcnt_d = wcnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge value of its peers. Bus data registers are reset too, because
    // a mid-job reset must drive every output to zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            n_q          <= '0;
            col_q        <= '0;
            wcnt_q       <= '0;
            bus_x_id_q   <= '0;
            fltr_data_q  <= '0;
            ifmap_data_q <= '0;
            fltr_en_q    <= 1'b0;
            ifmap_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            n_q          <= n_d;
            col_q        <= col_d;
            wcnt_q       <= wcnt_d;
            bus_x_id_q   <= bus_x_id_d;
            fltr_data_q  <= fltr_data_d;
            ifmap_data_q <= ifmap_data_d;
            fltr_en_q    <= fltr_en_d;
            ifmap_en_q   <= ifmap_en_d;
        end
    end

    assign bus_x_id        = bus_x_id_q;
    assign bus_fltr_data   = fltr_data_q;
    assign bus_fltr_en     = fltr_en_q;
    assign bus_ifmap_data  = ifmap_data_q;
    assign bus_ifmap_en    = ifmap_en_q;
    assign bus_kernel_size = k_q;

`ifdef XBUS_SCHED_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        stall_now;

    // A stall is a valid word on the stream of the current phase that the
    // addressed column refuses.
    assign stall_now = !pe_rdy_cur &&
                       (((state_q == S_FLTR)  && gb_fltr_valid) ||
                        ((state_q == S_IFMAP) && gb_ifmap_valid));

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == S_IDLE) && cfg_start)       stall_cnt_d = '0;
        else if (stall_now && (stall_cnt_q != '1))  stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_xbus_scheduler.sv
// -----------------------------------------------------------------------------
// tb_xbus_scheduler
//   Directed jobs for xbus_scheduler with a scoreboard: each job pushes its
//   expected bus words (kind, column, data) into a queue, and a monitor pops
//   and compares whenever the DUT raises bus_fltr_en or bus_ifmap_en.
//   The stimulus loop checks flush, busy, done timing, stalls, ignored
//   restarts and mid-job reset.
// -----------------------------------------------------------------------------
module tb_xbus_scheduler;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int CW = 16;

    logic          clk;
    logic          rstn;
    logic          cfg_start;
    logic [7:0]    cfg_kernel_size;
    logic [CW-1:0] cfg_num_ifmap;
    logic          gb_fltr_valid;
    logic [DW-1:0] gb_fltr_data;
    logic          gb_fltr_ready;
    logic          gb_ifmap_valid;
    logic [DW-1:0] gb_ifmap_data;
    logic          gb_ifmap_ready;
    logic [NC-1:0] pe_ready;
    logic [1:0]    bus_x_id;
    logic [DW-1:0] bus_fltr_data;
    logic          bus_fltr_en;
    logic [DW-1:0] bus_ifmap_data;
    logic          bus_ifmap_en;
    logic [7:0]    bus_kernel_size;
    logic          flush_kernel;
    logic          flush_tag;
    logic          busy;
    logic          done;
`ifdef XBUS_SCHED_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    xbus_scheduler #(.DATA_WIDTH(DW), .NUM_COL(NC), .CNT_W(CW)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .cfg_start       (cfg_start),
        .cfg_kernel_size (cfg_kernel_size),
        .cfg_num_ifmap   (cfg_num_ifmap),
        .gb_fltr_valid   (gb_fltr_valid),
        .gb_fltr_data    (gb_fltr_data),
        .gb_fltr_ready   (gb_fltr_ready),
        .gb_ifmap_valid  (gb_ifmap_valid),
        .gb_ifmap_data   (gb_ifmap_data),
        .gb_ifmap_ready  (gb_ifmap_ready),
        .pe_ready        (pe_ready),
        .bus_x_id        (bus_x_id),
        .bus_fltr_data   (bus_fltr_data),
        .bus_fltr_en     (bus_fltr_en),
        .bus_ifmap_data  (bus_ifmap_data),
        .bus_ifmap_en    (bus_ifmap_en),
        .bus_kernel_size (bus_kernel_size),
        .flush_kernel    (flush_kernel),
        .flush_tag       (flush_tag),
        .busy            (busy),
`ifdef XBUS_SCHED_STALL_CNT_EN
        .stall_cnt       (stall_cnt),
`endif
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ifmap;
        int unsigned x_id;
        int unsigned data;
    } exp_t;

    exp_t          exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            fidx, iidx;
    logic [DW-1:0] fbase, ibase;
    bit            fh, ih;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock: note handshakes before the edge, then present the next word
    // of each stream just after it.
    task automatic step();
        @(negedge clk);
        fh = gb_fltr_valid && gb_fltr_ready;
        ih = gb_ifmap_valid && gb_ifmap_ready;
        @(posedge clk);
        #1;
        if (fh) fidx++;
        if (ih) iidx++;
        gb_fltr_data  = fbase + DW'(fidx);
        gb_ifmap_data = ibase + DW'(iidx);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rstn && (bus_fltr_en || bus_ifmap_en)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL bus_unexpected: word 0x%0h x_id %0d with empty queue at %0t",
                         bus_ifmap_en ? bus_ifmap_data : bus_fltr_data, bus_x_id, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("bus_kind_ifmap", {31'd0, bus_ifmap_en}, {31'd0, e.ifmap});
                check("bus_x_id", {30'd0, bus_x_id}, e.x_id);
                check("bus_data", {16'd0, (bus_ifmap_en ? bus_ifmap_data : bus_fltr_data)}, e.data);
            end
        end
    end

    task automatic start_stream(input int k, input int n, input logic [DW-1:0] fb,
                                input logic [DW-1:0] ib);
        fbase = fb; ibase = ib; fidx = 0; iidx = 0;
        gb_fltr_data = fb; gb_ifmap_data = ib;
        for (int c = 0; c < NC; c++)
            for (int w = 0; w < k; w++)
                exp_q.push_back('{1'b0, c, 32'(fb) + c*k + w});
        for (int c = 0; c < NC; c++)
            for (int w = 0; w < n; w++)
                exp_q.push_back('{1'b1, c, 32'(ib) + c*n + w});
        cfg_kernel_size = 8'(k);
        cfg_num_ifmap   = CW'(n);
        cfg_start       = 1'b1;
        step();
        cfg_start       = 1'b0;
        // Scribble the config inputs to prove the job uses latched values.
        cfg_kernel_size = 8'd99;
        cfg_num_ifmap   = 16'd77;
    endtask

    task automatic run_job(input int k, input int n, input logic [DW-1:0] fb,
                           input logic [DW-1:0] ib, input int st_len, input bit mid_start);
        int cyc, busy_cnt, exp_done;
        bit stalled;
        stalled  = 1'b0;
        busy_cnt = 0;
        start_stream(k, n, fb, ib);
        cyc = 1;
        check("flush_kernel", {31'd0, flush_kernel}, 32'd1);
        check("flush_tag", {31'd0, flush_tag}, 32'd1);
        check("kernel_size_latched", {24'd0, bus_kernel_size}, 32'(k));
        forever begin
            if (busy) busy_cnt++;
            if (done || cyc >= 400) break;
            // Hold column 1 off once its first filter word is next in line.
            if (st_len > 0 && !stalled && fidx == k) begin
                stalled  = 1'b1;
                pe_ready = 4'b1101;
                for (int i = 0; i < st_len; i++) begin
                    if (i > 0 && busy) busy_cnt++;
                    #1;
                    check("stall_fltr_ready", {31'd0, gb_fltr_ready}, 32'd0);
                    if (i > 0) check("stall_fltr_en", {31'd0, bus_fltr_en}, 32'd0);
                    step();
                    cyc++;
                end
                pe_ready = 4'hF;
                #1;
                check("release_fltr_en", {31'd0, bus_fltr_en}, 32'd0);
                continue;
            end
            if (mid_start && cyc == 6) begin
                cfg_start       = 1'b1;
                cfg_kernel_size = 8'd5;
                cfg_num_ifmap   = 16'd9;
            end
            step();
            cfg_start = 1'b0;
            cyc++;
        end
        exp_done = 2 + NC*k + NC*n + st_len;
        check("done_cycle", 32'(cyc), 32'(exp_done));
        check("busy_cycles", 32'(busy_cnt), 32'(exp_done));
        check("kernel_size_held", {24'd0, bus_kernel_size}, 32'(k));
`ifdef XBUS_SCHED_STALL_CNT_EN
        check("stall_cnt", stall_cnt, 32'(st_len));
`endif
        for (int i = 0; i < 2; i++) begin
            step();
            check("done_single", {31'd0, done}, 32'd0);
            check("busy_idle", {31'd0, busy}, 32'd0);
        end
        check("words_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_flush"}, {30'd0, flush_kernel, flush_tag}, 32'd0);
        check({tag, "_bus_en"}, {30'd0, bus_fltr_en, bus_ifmap_en}, 32'd0);
        check({tag, "_bus_x_id"}, {30'd0, bus_x_id}, 32'd0);
        check({tag, "_bus_fltr_data"}, {16'd0, bus_fltr_data}, 32'd0);
        check({tag, "_bus_ifmap_data"}, {16'd0, bus_ifmap_data}, 32'd0);
        check({tag, "_kernel_size"}, {24'd0, bus_kernel_size}, 32'd0);
        check({tag, "_gb_ready"}, {30'd0, gb_fltr_ready, gb_ifmap_ready}, 32'd0);
`ifdef XBUS_SCHED_STALL_CNT_EN
        check({tag, "_stall_cnt"}, stall_cnt, 32'd0);
`endif
    endtask

    initial begin
        rstn            = 1'b0;
        cfg_start       = 1'b0;
        cfg_kernel_size = '0;
        cfg_num_ifmap   = '0;
        gb_fltr_valid   = 1'b1;
        gb_ifmap_valid  = 1'b1;
        gb_fltr_data    = '0;
        gb_ifmap_data   = '0;
        pe_ready        = 4'hF;
        fbase = '0; ibase = '0; fidx = 0; iidx = 0;
        #2;
        check_all_zero("reset");
        step();
        step();
        rstn = 1'b1;
        step();

        // Nominal job: 12 filter words then 8 ifmap words.
        run_job(3, 2, 16'h1000, 16'h2000, 0, 1'b0);
        // Column 1 refuses for 5 cycles during its filter load.
        run_job(2, 1, 16'h3000, 16'h4000, 5, 1'b0);
        // No filter phase.
        run_job(0, 3, 16'h5000, 16'h6000, 0, 1'b0);
        // Empty job: flush then done.
        run_job(0, 0, 16'h5500, 16'h6600, 0, 1'b0);
        // Second start during FLTR must be ignored.
        run_job(3, 2, 16'h7000, 16'h8000, 0, 1'b1);

        // Reset during IFMAP (K=1, N=2: IFMAP spans cycles 6..13).
        start_stream(1, 2, 16'h9000, 16'hA000);
        for (int i = 1; i < 10; i++) step();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        check_all_zero("midjob_reset");
        exp_q.delete();
        step();
        rstn = 1'b1;
        step();
        check("post_reset_idle", {31'd0, busy}, 32'd0);
        run_job(2, 2, 16'hB000, 16'hC000, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
